auto_nav_controller: RTL and testbench
======================================

Name: auto_nav_controller

Overview:
- Producer side of the motor command interface: generates auto_motor_state and obstacle_stop for the motor driver while the vehicle is in AUTO mode.
- Contains an HC-SR04-style ultrasonic ranger (trigger generation, echo pulse-width measurement) and a distance threshold with hysteresis.
- Contains an obstacle-avoidance FSM that sequences forward, stop, back up, turn.
- Sits between the sensor pins and the motor driver.

Parameters:
- CNT_W, 24, width of all cycle counters and echo_width.
- PERIOD_CYCLES, 6000000, ranging period (60 ms at 100 MHz).
- TRIG_CYCLES, 1000, trigger pulse length (10 us).
- ECHO_TIMEOUT, 2500000, max echo count; also reported as "no echo / far".
- STOP_THRESH, 116000, echo width below which target is near (~20 cm).
- CLEAR_THRESH, 140000, echo width at/above which near clears; must be > STOP_THRESH.
- STOP_HOLD_CYCLES, 20000000, time in HOLD.
- BACK_CYCLES, 30000000, time in BACK.
- TURN_CYCLES, 40000000, time in TURN.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- enable  in  1  high while the manual mode selector is AUTO
- echo  in  1  asynchronous ultrasonic echo pin
- trig  out  1  ultrasonic trigger pin, registered
- auto_motor_state  out  3  STOP 000, FORWARD 001, BACKWARD 010, LEFT 011, RIGHT 100; registered
- obstacle_stop  out  1  immediate-stop request, registered
- echo_width  out  CNT_W  last measured echo width in cycles
- meas_valid  out  1  one-cycle pulse when echo_width updates
- near  out  1  hysteresis obstacle flag

Behaviour:
- Reset values: trig=0, auto_motor_state=000, obstacle_stop=0, echo_width=ECHO_TIMEOUT, meas_valid=0, near=0, FSM=IDLE, turn_dir=LEFT, all counters 0.
- Echo synchronization:
  - echo passes through a 2-flop synchronizer.
  - Edges are detected on the synchronized signal, giving 2 cycles of latency.
- Ranger period and trigger:
  - period_cnt counts 0..PERIOD_CYCLES-1, then wraps.
  - The ranger runs regardless of enable.
  - trig=1 exactly while period_cnt < TRIG_CYCLES.
- Ranger measurement states: WAIT_RISE, COUNT, DONE.
  - Entered at WAIT_RISE when trig falls.
- Ranger measurement rules:
  - In WAIT_RISE, a rising echo edge clears echo_cnt and moves to COUNT.
  - In COUNT, echo_cnt increments each cycle while echo is high.
  - Falling edge: echo_width<=echo_cnt, meas_valid=1 for the next cycle, then DONE.
  - echo_cnt reaching ECHO_TIMEOUT: echo_width<=ECHO_TIMEOUT, meas_valid pulse, then DONE.
  - No rising edge within ECHO_TIMEOUT cycles of trig falling: same result as timeout.
  - DONE ignores echo until the next trig falls.
  - Period wrap while in WAIT_RISE/COUNT: abort, no meas_valid.
- Hysteresis, evaluated on the cycle after meas_valid:
  - near<=1 if echo_width < STOP_THRESH.
  - near<=0 if echo_width >= CLEAR_THRESH.
  - Otherwise hold.
- Navigation FSM states: IDLE, FWD, HOLD, BACK, TURN.
- Global rule: enable=0 forces IDLE from any state on the next edge, with auto_motor_state=000 and obstacle_stop=0; the phase timer clears and turn_dir is preserved.
- State outputs and transitions:
  - IDLE: output STOP. Goes to FWD when enable=1.
  - FWD: output FORWARD. Goes to HOLD when near=1 (level, not edge).
  - HOLD: output STOP, obstacle_stop=1. Lasts exactly STOP_HOLD_CYCLES, then BACK.
  - BACK: output BACKWARD. Lasts exactly BACK_CYCLES, then TURN.
  - TURN: output LEFT if turn_dir=0, RIGHT if turn_dir=1. Lasts exactly TURN_CYCLES; on exit turn_dir toggles and the FSM goes to FWD.
  - FWD re-entered with near still 1: goes to HOLD on the next cycle.
- Phase timer:
  - Loaded with N-1 on state entry, decrements each cycle; the state exits when the timer is 0.
  - A value of 0 for N behaves as 1.
- Latency: meas_valid at cycle t gives near at t+1, and the HOLD outputs (auto_motor_state=000, obstacle_stop=1) at t+2.
- obstacle_stop is high only in HOLD; it deasserts when entering BACK.
- near and enable are never sampled during HOLD/BACK/TURN, except for the enable-low abort.

Decomposition:
- Shared package motor_pkg: the motor state encodings (STOP/FORWARD/BACKWARD/LEFT/RIGHT, manual AUTO=110), used by this block and the motor driver.
- Sub-module ultrasonic_ranger: synchronizer, period/trigger counter, measurement FSM, and the echo_width/meas_valid outputs.
- The top level holds the hysteresis and the navigation FSM.

Test Plan:
Common overrides: TRIG_CYCLES=4, PERIOD_CYCLES=200, ECHO_TIMEOUT=150, STOP_THRESH=40, CLEAR_THRESH=60, STOP_HOLD_CYCLES=5, BACK_CYCLES=10, TURN_CYCLES=8.
- Reset released, enable=1, echo held at 0:
  - trig is high for cycles 0-3 of each 200-cycle period.
  - meas_valid pulses with echo_width=150; near=0.
  - auto_motor_state=001 from the second cycle after enable.
- Echo high for 30 cycles:
  - echo_width=30 (±1 for the synchronizer) and near=1.
  - auto_motor_state=000 with obstacle_stop=1 for 5 cycles.
  - Then 010 for 10 cycles, then 011 for 8 cycles, then 001.
- A second obstacle event: the turn phase outputs 100 (RIGHT).
- Echo 50 cycles after near=1: near stays 1. Echo 70 cycles: near clears.
- Echo 30 cycles then 50 cycles from near=0: near sets, then holds.
- enable dropped mid-BACK: outputs are 000/0 the next cycle, FSM is IDLE; enable=1 resumes at FWD.
- Asynchronous rst pulsed mid-TURN: all outputs take their reset values immediately; turn_dir returns to LEFT.
- Echo stuck high: echo_width=150 (timeout), echo is ignored until the next trigger, and near is unaffected.

Source files
------------

// File: rtl/motor_pkg.sv
// Motor command encodings shared by the autonomous controller and the motor driver,
// plus small constant helpers for sizing the navigation phase timer.
package motor_pkg;

   typedef enum logic [2:0] {
      MOTOR_STOP     = 3'b000,
      MOTOR_FORWARD  = 3'b001,
      MOTOR_BACKWARD = 3'b010,
      MOTOR_LEFT     = 3'b011,
      MOTOR_RIGHT    = 3'b100,
      MOTOR_AUTO     = 3'b110
   } motor_state_t;

   // Reload value for an N-cycle phase; N=0 is treated as a 1-cycle phase.
   function automatic int unsigned phase_load(input int unsigned n);
      return (n == 32'd0) ? 32'd0 : n - 32'd1;
   endfunction

   // Bits needed to hold the largest reload value among three phase lengths.
   function automatic int unsigned timer_width(input int unsigned a, input int unsigned b,
                                               input int unsigned c);
      int unsigned m;
      m = (a > b) ? a : b;
      m = (m > c) ? m : c;
      return (m < 32'd2) ? 32'd1 : $clog2(m);
   endfunction

endpackage

// File: rtl/ultrasonic_ranger.sv
// HC-SR04 style ranger: periodic trigger, synchronized echo capture and pulse-width
// measurement with timeout. Publishes echo_width together with a one-cycle meas_valid.
module ultrasonic_ranger #(
   parameter int unsigned CNT_W         = 24,
   parameter int unsigned PERIOD_CYCLES = 6000000,
   parameter int unsigned TRIG_CYCLES   = 1000,
   parameter int unsigned ECHO_TIMEOUT  = 2500000
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             echo,
   output logic             trig,
   output logic [CNT_W-1:0] echo_width,
   output logic             meas_valid
);

   typedef enum logic [1:0] {
      WAIT_RISE,
      COUNT,
      DONE
   } meas_state_t;

   localparam logic [CNT_W-1:0] PERIOD_LAST  = CNT_W'(PERIOD_CYCLES - 1);
   localparam logic [CNT_W-1:0] TRIG_LEN     = CNT_W'(TRIG_CYCLES);
   localparam logic [CNT_W-1:0] TIMEOUT      = CNT_W'(ECHO_TIMEOUT);
   localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(ECHO_TIMEOUT - 1);

   logic             echo_meta;
   logic             echo_sync;
   logic             echo_prev;
   logic             echo_rise;
   logic             echo_fall;
   logic [CNT_W-1:0] period_cnt;
   logic [CNT_W-1:0] period_next;
   logic             period_wrap;
   logic             trig_next;
   logic             trig_fall;
   logic [CNT_W-1:0] echo_cnt;
   meas_state_t      meas_state;

   // NOTE: clocked blocks use non-blocking assignments so the synchronizer stages
   // shift one flop per edge instead of collapsing into a single flop.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         echo_meta <= 1'b0;
         echo_sync <= 1'b0;
         echo_prev <= 1'b0;
      end else begin
         echo_meta <= echo;
         echo_sync <= echo_meta;
         echo_prev <= echo_sync;
      end
   end

   assign echo_rise = echo_sync & ~echo_prev;
   assign echo_fall = ~echo_sync & echo_prev;

   assign period_wrap = (period_cnt == PERIOD_LAST);
   assign period_next = period_wrap ? '0 : period_cnt + 1'b1;
   // trig is registered from the next count so it tracks period_cnt without lag.
   assign trig_next   = (period_next < TRIG_LEN);
   assign trig_fall   = trig & ~trig_next;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         period_cnt <= '0;
         trig       <= 1'b0;
      end else begin
         period_cnt <= period_next;
         trig       <= trig_next;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         meas_state <= DONE;
         echo_cnt   <= '0;
         echo_width <= TIMEOUT;
         meas_valid <= 1'b0;
      end else begin
         meas_valid <= 1'b0;
         if (trig_fall) begin
            meas_state <= WAIT_RISE;
            echo_cnt   <= '0;
         end else if (period_wrap && (meas_state != DONE)) begin
            meas_state <= DONE;
         end else begin
            unique case (meas_state)
               WAIT_RISE: begin
                  // While waiting, echo_cnt measures time since trig fell.
                  if (echo_rise) begin
                     echo_cnt   <= '0;
                     meas_state <= COUNT;
                  end else if (echo_cnt == TIMEOUT_LAST) begin
                     echo_width <= TIMEOUT;
                     meas_valid <= 1'b1;
                     meas_state <= DONE;
                  end else begin
                     echo_cnt <= echo_cnt + 1'b1;
                  end
               end
               COUNT: begin
                  if (echo_fall) begin
                     echo_width <= echo_cnt;
                     meas_valid <= 1'b1;
                     meas_state <= DONE;
                  end else if (echo_cnt == TIMEOUT_LAST) begin
                     echo_width <= TIMEOUT;
                     meas_valid <= 1'b1;
                     meas_state <= DONE;
                  end else begin
                     echo_cnt <= echo_cnt + 1'b1;
                  end
               end
               DONE: ;
               default: meas_state <= DONE;
            endcase
         end
      end
   end

endmodule

// File: rtl/auto_nav_controller.sv
// Autonomous navigation: ranger-driven near flag with hysteresis and an obstacle
// avoidance FSM (forward, hold, back up, turn) producing registered motor commands.
module auto_nav_controller
   import motor_pkg::*;
#(
   parameter int unsigned CNT_W            = 24,
   parameter int unsigned PERIOD_CYCLES    = 6000000,
   parameter int unsigned TRIG_CYCLES      = 1000,
   parameter int unsigned ECHO_TIMEOUT     = 2500000,
   parameter int unsigned STOP_THRESH      = 116000,
   parameter int unsigned CLEAR_THRESH     = 140000,
   parameter int unsigned STOP_HOLD_CYCLES = 20000000,
   parameter int unsigned BACK_CYCLES      = 30000000,
   parameter int unsigned TURN_CYCLES      = 40000000
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             enable,
   input  logic             echo,
   output logic             trig,
   output logic [2:0]       auto_motor_state,
   output logic             obstacle_stop,
   output logic [CNT_W-1:0] echo_width,
   output logic             meas_valid,
   output logic             near
);

   typedef enum logic [2:0] {
      IDLE,
      FWD,
      HOLD,
      BACK,
      TURN
   } nav_state_t;

   // Phase lengths can exceed the ranger counter width, so the timer is sized on its own.
   localparam int unsigned PHASE_W = timer_width(STOP_HOLD_CYCLES, BACK_CYCLES, TURN_CYCLES);
   localparam logic [PHASE_W-1:0] HOLD_LOAD = PHASE_W'(phase_load(STOP_HOLD_CYCLES));
   localparam logic [PHASE_W-1:0] BACK_LOAD = PHASE_W'(phase_load(BACK_CYCLES));
   localparam logic [PHASE_W-1:0] TURN_LOAD = PHASE_W'(phase_load(TURN_CYCLES));
   localparam logic [CNT_W-1:0]   STOP_TH   = CNT_W'(STOP_THRESH);
   localparam logic [CNT_W-1:0]   CLEAR_TH  = CNT_W'(CLEAR_THRESH);

   nav_state_t         state;
   nav_state_t         state_next;
   logic [PHASE_W-1:0] phase_cnt;
   logic [PHASE_W-1:0] phase_next;
   logic               turn_dir;
   logic               turn_dir_next;
   motor_state_t       motor_next;
   logic               obstacle_next;

   ultrasonic_ranger #(
      .CNT_W        (CNT_W),
      .PERIOD_CYCLES(PERIOD_CYCLES),
      .TRIG_CYCLES  (TRIG_CYCLES),
      .ECHO_TIMEOUT (ECHO_TIMEOUT)
   ) u_ranger (
      .clk       (clk),
      .rst       (rst),
      .echo      (echo),
      .trig      (trig),
      .echo_width(echo_width),
      .meas_valid(meas_valid)
   );

   // Widths between the two thresholds keep the previous decision.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         near <= 1'b0;
      end else if (meas_valid) begin
         if (echo_width < STOP_TH) begin
            near <= 1'b1;
         end else if (echo_width >= CLEAR_TH) begin
            near <= 1'b0;
         end
      end
   end

   // NOTE: every signal written here gets a default first, so no path leaves it
   // unassigned and no latch is inferred.
   always_comb begin
      state_next    = state;
      phase_next    = phase_cnt;
      turn_dir_next = turn_dir;
      if (!enable) begin
         state_next = IDLE;
         phase_next = '0;
      end else begin
         unique case (state)
            IDLE: state_next = FWD;
            FWD: begin
               if (near) begin
                  state_next = HOLD;
                  phase_next = HOLD_LOAD;
               end
            end
            HOLD: begin
               if (phase_cnt == '0) begin
                  state_next = BACK;
                  phase_next = BACK_LOAD;
               end else begin
                  phase_next = phase_cnt - 1'b1;
               end
            end
            BACK: begin
               if (phase_cnt == '0) begin
                  state_next = TURN;
                  phase_next = TURN_LOAD;
               end else begin
                  phase_next = phase_cnt - 1'b1;
               end
            end
            TURN: begin
               if (phase_cnt == '0) begin
                  state_next    = FWD;
                  phase_next    = '0;
                  turn_dir_next = ~turn_dir;
               end else begin
                  phase_next = phase_cnt - 1'b1;
               end
            end
            default: begin
               state_next = IDLE;
               phase_next = '0;
            end
         endcase
      end

      // Outputs are decoded from the next state so the registered pins match the state.
      motor_next    = MOTOR_STOP;
      obstacle_next = 1'b0;
      unique case (state_next)
         FWD:     motor_next = MOTOR_FORWARD;
         HOLD:    obstacle_next = 1'b1;
         BACK:    motor_next = MOTOR_BACKWARD;
         TURN:    motor_next = turn_dir_next ? MOTOR_RIGHT : MOTOR_LEFT;
         default: motor_next = MOTOR_STOP;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state            <= IDLE;
         phase_cnt        <= '0;
         turn_dir         <= 1'b0;
         auto_motor_state <= MOTOR_STOP;
         obstacle_stop    <= 1'b0;
      end else begin
         state            <= state_next;
         phase_cnt        <= phase_next;
         turn_dir         <= turn_dir_next;
         auto_motor_state <= motor_next;
         obstacle_stop    <= obstacle_next;
      end
   end

endmodule

// File: tb/tb_auto_nav_controller.sv
// Directed bench for auto_nav_controller with shortened timing parameters:
// ranger shape, timeout, hysteresis table and obstacle-avoidance sequences.
module tb_auto_nav_controller;

   localparam int unsigned CNT_W = 24;

   logic             clk;
   logic             rst;
   logic             enable;
   logic             echo;
   logic             trig;
   logic [2:0]       auto_motor_state;
   logic             obstacle_stop;
   logic [CNT_W-1:0] echo_width;
   logic             meas_valid;
   logic             near;

   int checks = 0;
   int errors = 0;

   typedef struct {
      int               echo_len;
      logic [CNT_W-1:0] width;
      logic             near;
   } vec_t;

   vec_t vecs [9];

   auto_nav_controller #(
      .CNT_W           (CNT_W),
      .PERIOD_CYCLES   (200),
      .TRIG_CYCLES     (4),
      .ECHO_TIMEOUT    (150),
      .STOP_THRESH     (40),
      .CLEAR_THRESH    (60),
      .STOP_HOLD_CYCLES(5),
      .BACK_CYCLES     (10),
      .TURN_CYCLES     (8)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .enable          (enable),
      .echo            (echo),
      .trig            (trig),
      .auto_motor_state(auto_motor_state),
      .obstacle_stop   (obstacle_stop),
      .echo_width      (echo_width),
      .meas_valid      (meas_valid),
      .near            (near)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic wait_trig_fall();
      int n;
      n = 0;
      while (trig !== 1'b1 && n < 400) begin
         @(negedge clk);
         n++;
      end
      while (trig !== 1'b0 && n < 400) begin
         @(negedge clk);
         n++;
      end
      check("trig_fall_seen", n < 400, 1);
   endtask

   task automatic pulse_echo(input int len);
      repeat (3) @(negedge clk);
      if (len > 0) begin
         echo = 1'b1;
         repeat (len) @(negedge clk);
         echo = 1'b0;
      end
   endtask

   task automatic wait_meas(output logic seen);
      seen = 1'b0;
      for (int i = 0; i < 300 && !seen; i++) begin
         @(negedge clk);
         if (meas_valid === 1'b1) seen = 1'b1;
      end
      check("meas_valid_seen", seen, 1);
   endtask

   // Checks {obstacle_stop, auto_motor_state} for len cycles, ending one cycle later.
   task automatic expect_run(input string name, input logic [3:0] exp, input int len);
      for (int i = 0; i < len; i++) begin
         check($sformatf("%s[%0d]", name, i), {obstacle_stop, auto_motor_state}, exp);
         @(negedge clk);
      end
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, "_trig"}, trig, 0);
      check({tag, "_motor"}, auto_motor_state, 3'b000);
      check({tag, "_obstacle"}, obstacle_stop, 0);
      check({tag, "_width"}, echo_width, 150);
      check({tag, "_meas_valid"}, meas_valid, 0);
      check({tag, "_near"}, near, 0);
   endtask

   initial begin
      logic seen;
      int   n;

      vecs[0] = '{0,  24'd150, 1'b0};
      vecs[1] = '{41, 24'd40,  1'b0};
      vecs[2] = '{40, 24'd39,  1'b1};
      vecs[3] = '{50, 24'd49,  1'b1};
      vecs[4] = '{60, 24'd59,  1'b1};
      vecs[5] = '{61, 24'd60,  1'b0};
      vecs[6] = '{30, 24'd29,  1'b1};
      vecs[7] = '{70, 24'd69,  1'b0};
      vecs[8] = '{50, 24'd49,  1'b0};

      rst    = 1'b1;
      enable = 1'b0;
      echo   = 1'b0;
      repeat (3) @(negedge clk);
      check_reset_values("reset");
      rst = 1'b0;
      @(negedge clk);
      check("idle_motor", {obstacle_stop, auto_motor_state}, 4'b0000);
      enable = 1'b1;
      @(negedge clk);
      check("fwd_after_enable", {obstacle_stop, auto_motor_state}, 4'b0001);

      // Trigger shape over one full period after the shortened first one.
      wait_trig_fall();
      n = 0;
      while (trig === 1'b0 && n < 400) begin
         @(negedge clk);
         n++;
      end
      check("trig_low_len", n, 196);
      n = 0;
      while (trig === 1'b1 && n < 400) begin
         @(negedge clk);
         n++;
      end
      check("trig_high_len", n, 4);

      // No echo at all: timeout measurement, nothing near.
      wait_meas(seen);
      check("noecho_width", echo_width, 150);
      @(negedge clk);
      check("noecho_near", near, 0);
      check("noecho_motor", {obstacle_stop, auto_motor_state}, 4'b0001);

      // First obstacle, FWD re-entry with near still set, enable drop mid-BACK.
      wait_trig_fall();
      pulse_echo(30);
      wait_meas(seen);
      check("obs1_width", echo_width, 29);
      @(negedge clk);
      check("obs1_near", near, 1);
      check("obs1_still_fwd", {obstacle_stop, auto_motor_state}, 4'b0001);
      @(negedge clk);
      expect_run("hold1", 4'b1000, 5);
      expect_run("back1", 4'b0010, 10);
      expect_run("turn1_left", 4'b0011, 8);
      expect_run("fwd1", 4'b0001, 1);
      expect_run("hold2", 4'b1000, 5);
      expect_run("back2", 4'b0010, 3);
      enable = 1'b0;
      @(negedge clk);
      check("abort_idle0", {obstacle_stop, auto_motor_state}, 4'b0000);
      @(negedge clk);
      check("abort_idle1", {obstacle_stop, auto_motor_state}, 4'b0000);
      enable = 1'b1;
      @(negedge clk);
      check("resume_fwd", {obstacle_stop, auto_motor_state}, 4'b0001);
      @(negedge clk);
      expect_run("hold3", 4'b1000, 5);
      expect_run("back3", 4'b0010, 10);
      expect_run("turn3_right", 4'b0100, 3);

      // Asynchronous reset mid-TURN, checked before the next clock edge.
      #2 rst = 1'b1;
      #1 check_reset_values("async_rst");
      @(negedge clk);
      rst = 1'b0;

      // Echo stuck high: timeout width, ignored until the next trigger, near untouched.
      wait_trig_fall();
      repeat (3) @(negedge clk);
      echo = 1'b1;
      wait_meas(seen);
      check("stuck_width", echo_width, 150);
      @(negedge clk);
      check("stuck_near", near, 0);
      check("stuck_motor", {obstacle_stop, auto_motor_state}, 4'b0001);
      n = 0;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         if (meas_valid === 1'b1) n++;
      end
      check("stuck_ignored", n, 0);
      wait_meas(seen);
      check("stuck_width2", echo_width, 150);
      @(negedge clk);
      check("stuck_near2", near, 0);
      echo = 1'b0;

      // Obstacle after reset turns LEFT again.
      wait_trig_fall();
      pulse_echo(30);
      wait_meas(seen);
      check("obs4_width", echo_width, 29);
      @(negedge clk);
      check("obs4_near", near, 1);
      @(negedge clk);
      expect_run("hold4", 4'b1000, 5);
      expect_run("back4", 4'b0010, 10);
      expect_run("turn4_left", 4'b0011, 8);

      // Hysteresis table with the FSM parked in IDLE.
      enable = 1'b0;
      for (int i = 0; i < 9; i++) begin
         wait_trig_fall();
         pulse_echo(vecs[i].echo_len);
         wait_meas(seen);
         check($sformatf("vec%0d_width", i), echo_width, vecs[i].width);
         @(negedge clk);
         check($sformatf("vec%0d_near", i), near, vecs[i].near);
         check($sformatf("vec%0d_motor", i), {obstacle_stop, auto_motor_state}, 4'b0000);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
